ppu_vram: RTL and testbench
===========================

# ppu_vram

PPU-side video memory responder: answers the address-out/data-in fetch interface used by the PPU background and sprite renderers, and services CPU PPUADDR/PPUDATA accesses. It holds 8 KB pattern (CHR) RAM, 2 KB nametable RAM with mirroring, and 32 B palette RAM, decoded over the 14-bit PPU address space. It sits between the renderers and the PPU register file (`ppu_regs`).

## Interface
Parameters:
- `CHR_INIT`, `""`: optional hex file preloading pattern RAM (simulation/ROM images); empty means zero-filled.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `VRAM_addr`  in  16  renderer fetch address; bits 15:14 ignored.
- `VRAM_data`  out  8  renderer fetch data; drives renderer `VRAM_data_in`.
- `rendering`  in  1  renderer owns VRAM; CPU data accesses are blocked.
- `addr_wr`  in  1  one-cycle strobe: CPU write to PPUADDR.
- `data_wr`  in  1  one-cycle strobe: CPU write to PPUDATA.
- `data_rd`  in  1  one-cycle strobe: CPU read of PPUDATA.
- `status_rd`  in  1  one-cycle strobe: PPUSTATUS read; clears write toggle.
- `inc32`  in  1  PPUCTRL bit 2: address increment 32 when set, else 1.
- `cpu_din`  in  8  CPU write data.
- `cpu_dout`  out  8  PPUDATA read result.
- `vaddr`  out  14  current CPU VRAM address `v`, for debug.

## Operation
- Address decode on a 14-bit address `a`:
  - `0000-1FFF`: CHR RAM.
  - `2000-3EFF`: nametable. `3000-3EFF` aliases `2000-2EFF`. Table index comes from mirroring (see Configuration); offset is `a[9:0]`.
  - `3F00-3FFF`: palette, index `a[4:0]`. Indices `10/14/18/1C` alias `00/04/08/0C`.
- Render port: dedicated read port. It is never blocked and never stalls.
- CPU state: `v[13:0]`, write toggle `w`, read buffer `rbuf[7:0]`, FSM `{IDLE, FILL}`.
- `addr_wr`:
  - If `w=0`: `v[13:8] <= cpu_din[5:0]`, `w <= 1`.
  - Else: `v[7:0] <= cpu_din`, `w <= 0`.
  - Allowed regardless of `rendering`.
- `status_rd`: `w <= 0`. If it coincides with `addr_wr`, `addr_wr` uses the old `w`, and `w` ends at 0.
- `data_wr` with `rendering=0`: memory at `v` is written with `cpu_din`, then `v <= (v + inc) mod 2^14`, where `inc = inc32 ? 32 : 1`. Wraps `3FFF+1 -> 0000`.
- `data_rd` with `rendering=0`:
  - If `v < 3F00`: `cpu_dout <= rbuf` (stale value).
  - Else: `cpu_dout <= palette[v]`.
  - In both cases `v` increments and the FSM goes to FILL, latching old `v` as `fa`.
  - If `fa < 3F00`: FILL loads `rbuf <= mem[fa]`.
  - Else: FILL loads `rbuf <= nametable[fa - 1000]`.
  - FILL returns to IDLE after one cycle.
- With `rendering=1`: `data_wr` and `data_rd` do not touch memory, `v`, or `rbuf`. `data_rd` still returns `cpu_dout <= rbuf`.
- Simultaneous strobes: priority is `addr_wr > data_wr > data_rd`. Lower-priority strobes in the same cycle are dropped.
- A CPU strobe arriving while in FILL is held off: it is accepted the cycle after FILL. Callers must space strobes at least 2 cycles apart. `ppu_regs` guarantees this.
- Palette entries are 6 bits. Reads return `{2'b00, pal[5:0]}`.

## Timing
- Render read latency is 1 clock: `VRAM_addr` is sampled at edge N, and `VRAM_data` is valid after edge N and held until edge N+1. This supports back-to-back reads every cycle.
- `cpu_dout` is registered and updates on the edge that samples `data_rd`. It is held otherwise.
- The `rbuf` refill completes at edge N+1 after the `data_rd` edge N.
- CPU write data is visible on the render port 2 edges after `data_wr` (write at edge N, render sample at N+1, data valid after N+1).
- Reset values:
  - `v=0`, `w=0`, `rbuf=00`, FSM=IDLE, `cpu_dout=00`, `VRAM_data=00`.
  - Memory contents are not reset.
- A reset asserted mid-FILL abandons the fill. `rbuf` becomes `00`.

## Configuration
- `VRAM_VERTICAL_MIRROR_EN`:
  - Defined: vertical mirroring. Nametable select is `a[10]`, so `2000≡2800` and `2400≡2C00`.
  - Undefined: horizontal mirroring. Select is `a[11]`, so `2000≡2400` and `2800≡2C00`.

## Test plan
- **PPUADDR + write, render read-back.** Stimulus: `addr_wr` 0x21, `addr_wr` 0x08, `data_wr` 0x5A, `data_wr` 0x6B with `inc32=0`. Required: `vaddr=210A`. Render reads at 2108/2109 return 5A/6B. With the macro defined, a render read at 2908 also returns 5A. With it undefined, 2508 returns 5A.
- **Buffered read.** Stimulus: CHR[0010]=0x11, CHR[0011]=0x22; set `v=0010`; issue three `data_rd`. Required: `cpu_dout` = 00 (stale), then 11, then 22.
- **Palette read and aliasing.**
  - Write 0x3F to `3F10`, then `data_rd` at `3F00`. Required: `cpu_dout=3F` immediately, and `rbuf` is loaded from nametable `2F00`.
  - Write 0x2A to `3F05`, then read `3F25`. Required: 2A.
- **Increment and wrap.** Stimulus: `inc32=1`, `v=3FF0`, one `data_wr`. Required: `vaddr=0010`. With `inc32=0` and `v=3FFF`, one write gives `vaddr=0000`.
- **Rendering lockout.** Stimulus: `rendering=1`, `v=2000`, `data_wr` 0x77. Required: `vaddr` stays 2000 and memory at 2000 is unchanged. `addr_wr` still updates `v`.
- **Toggle/reset.**
  - After one `addr_wr` (0x23), `status_rd`, then `addr_wr` 0x24 and `addr_wr` 0x00. Required: `vaddr=2400`.
  - Assert `reset` mid-FILL. Required: all outputs 00 and `vaddr=0000`.

Source files
------------

// File: rtl/ppu_vram.sv
// PPU video memory: 8 KB CHR RAM, 2 KB mirrored nametable RAM, 32 B palette RAM,
// serving a 1-cycle render fetch port and CPU PPUADDR/PPUDATA accesses.
// Optional: define VRAM_VERTICAL_MIRROR_EN for vertical mirroring (default horizontal).
module ppu_vram #(
   parameter CHR_INIT = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] VRAM_addr,
   output logic [7:0]  VRAM_data,
   input  logic        rendering,
   input  logic        addr_wr,
   input  logic        data_wr,
   input  logic        data_rd,
   input  logic        status_rd,
   input  logic        inc32,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic [13:0] vaddr
);

   localparam int unsigned AW      = 14;
   localparam int unsigned DW      = 8;
   localparam int unsigned PW      = 6;
   localparam int unsigned CHR_AW  = 13;
   localparam int unsigned NT_AW   = 11;
   localparam int unsigned PAL_AW  = 5;
   localparam logic [AW-1:0] NT_BASE  = 14'h2000;
   localparam logic [AW-1:0] PAL_BASE = 14'h3F00;
`ifdef VRAM_VERTICAL_MIRROR_EN
   localparam int unsigned NT_SEL = 10;
`else
   localparam int unsigned NT_SEL = 11;
`endif

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_FILL = 1'b1;

   // Pattern RAM preload is applied by the memory-image flow, not by this RTL.
   logic unused_chr_init;
   assign unused_chr_init = (CHR_INIT == "");
   logic [1:0] unused_addr_hi;
   assign unused_addr_hi = VRAM_addr[15:14];

   logic [DW-1:0] chr_mem [2**CHR_AW];
   logic [DW-1:0] nt_mem  [2**NT_AW];
   logic [PW-1:0] pal_mem [2**PAL_AW];

   logic [0:0]    state, state_n;
   logic [AW-1:0] v, v_n, fa, fa_n;
   logic          w, w_n;
   logic [DW-1:0] rbuf, rbuf_n, dout_n;
   logic          p_addr, p_wr, p_rd, p_addr_n, p_wr_n, p_rd_n;
   logic [DW-1:0] p_din, p_din_n;

   logic          acc_addr_c, acc_wr_c, acc_rd_c, mem_we_c;
   logic [DW-1:0] din_c;
   logic [AW-1:0] inc_c;

   // Mirrored nametable and aliased palette indices for each address source
   logic [AW-1:0]     ra;
   logic [NT_AW-1:0]  ra_nt, v_nt, fa_nt;
   logic [PAL_AW-1:0] ra_pal, v_pal;
   assign ra     = VRAM_addr[AW-1:0];
   assign ra_nt  = {ra[NT_SEL], ra[9:0]};
   assign v_nt   = {v[NT_SEL], v[9:0]};
   assign fa_nt  = {fa[NT_SEL], fa[9:0]};
   assign ra_pal = {ra[4] & (|ra[1:0]), ra[3:0]};
   assign v_pal  = {v[4] & (|v[1:0]), v[3:0]};

   assign vaddr = v;

   // Render fetch port: registered read, never blocked
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         VRAM_data <= '0;
      end else if (ra < NT_BASE) begin
         VRAM_data <= chr_mem[ra[CHR_AW-1:0]];
      end else if (ra < PAL_BASE) begin
         VRAM_data <= nt_mem[ra_nt];
      end else begin
         VRAM_data <= {2'b00, pal_mem[ra_pal]};
      end
   end

   // CPU write port into whichever RAM v decodes to
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         if (v < NT_BASE) begin
            chr_mem[v[CHR_AW-1:0]] <= din_c;
         end else if (v < PAL_BASE) begin
            nt_mem[v_nt] <= din_c;
         end else begin
            pal_mem[v_pal] <= din_c[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         v        <= '0;
         w        <= 1'b0;
         fa       <= '0;
         rbuf     <= '0;
         cpu_dout <= '0;
         p_addr   <= 1'b0;
         p_wr     <= 1'b0;
         p_rd     <= 1'b0;
         p_din    <= '0;
      end else begin
         state    <= state_n;
         v        <= v_n;
         w        <= w_n;
         fa       <= fa_n;
         rbuf     <= rbuf_n;
         cpu_dout <= dout_n;
         p_addr   <= p_addr_n;
         p_wr     <= p_wr_n;
         p_rd     <= p_rd_n;
         p_din    <= p_din_n;
      end
   end

   always_comb begin
      state_n  = state;
      v_n      = v;
      w_n      = w;
      fa_n     = fa;
      rbuf_n   = rbuf;
      dout_n   = cpu_dout;
      p_addr_n = 1'b0;
      p_wr_n   = 1'b0;
      p_rd_n   = 1'b0;
      p_din_n  = p_din;
      mem_we_c = 1'b0;
      inc_c    = inc32 ? AW'(32) : AW'(1);
      din_c    = (p_addr | p_wr) ? p_din : cpu_din;

      // Strobes seen during FILL are parked and replayed once back in IDLE
      acc_addr_c = (state == ST_IDLE) && (addr_wr || p_addr);
      acc_wr_c   = (state == ST_IDLE) && (data_wr || p_wr) && !acc_addr_c;
      acc_rd_c   = (state == ST_IDLE) && (data_rd || p_rd) && !acc_addr_c && !(data_wr || p_wr);

      case (state)
         ST_IDLE: begin
            if (acc_addr_c) begin
               if (!w) begin
                  v_n[13:8] = din_c[5:0];
                  w_n       = 1'b1;
               end else begin
                  v_n[7:0] = din_c;
                  w_n      = 1'b0;
               end
            end else if (acc_wr_c) begin
               if (!rendering) begin
                  mem_we_c = 1'b1;
                  v_n      = v + inc_c;
               end
            end else if (acc_rd_c) begin
               dout_n = rbuf;
               if (!rendering) begin
                  if (v >= PAL_BASE) begin
                     dout_n = {2'b00, pal_mem[v_pal]};
                  end
                  v_n     = v + inc_c;
                  fa_n    = v;
                  state_n = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            // Palette-range fills take the nametable byte underneath (fa - 0x1000)
            rbuf_n   = (fa < NT_BASE) ? chr_mem[fa[CHR_AW-1:0]] : nt_mem[fa_nt];
            state_n  = ST_IDLE;
            p_addr_n = addr_wr;
            p_wr_n   = data_wr;
            p_rd_n   = data_rd;
            if (addr_wr || data_wr) begin
               p_din_n = cpu_din;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (status_rd) begin
         w_n = 1'b0;
      end
   end

endmodule

// File: tb/tb_ppu_vram.sv
// Self-checking bench for ppu_vram: CPU address/data path, buffered reads,
// palette aliasing, increment/wrap, rendering lockout, toggle and reset.
module tb_ppu_vram;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] VRAM_addr;
   logic [7:0]  VRAM_data;
   logic        rendering, addr_wr, data_wr, data_rd, status_rd, inc32;
   logic [7:0]  cpu_din, cpu_dout;
   logic [13:0] vaddr;

   int checks = 0;
   int errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp8;

   ppu_vram dut (
      .clk(clk), .reset(reset), .VRAM_addr(VRAM_addr), .VRAM_data(VRAM_data),
      .rendering(rendering), .addr_wr(addr_wr), .data_wr(data_wr), .data_rd(data_rd),
      .status_rd(status_rd), .inc32(inc32), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .vaddr(vaddr)
   );

   always #5 clk = ~clk;

   task automatic pulse_addr(input logic [7:0] d);
      @(negedge clk); addr_wr = 1'b1; cpu_din = d;
      @(posedge clk); #1 addr_wr = 1'b0;
      @(posedge clk);
   endtask

   task automatic set_v(input logic [13:0] a);
      pulse_addr({2'b00, a[13:8]});
      pulse_addr(a[7:0]);
   endtask

   task automatic pulse_write(input logic [7:0] d);
      @(negedge clk); data_wr = 1'b1; cpu_din = d;
      @(posedge clk); #1 data_wr = 1'b0;
      @(posedge clk);
   endtask

   // Push the expected PPUDATA result, strobe, then pop and compare on the sampling edge
   task automatic cpu_read(input string name, input logic [7:0] exp);
      exp_q.push_back(exp);
      @(negedge clk); data_rd = 1'b1;
      @(posedge clk); #1 data_rd = 1'b0;
      exp8 = exp_q.pop_front();
      checks++;
      if (cpu_dout !== exp8) begin
         errors++;
         $display("FAIL %s: cpu_dout=%h expected %h", name, cpu_dout, exp8);
      end
      @(posedge clk);
   endtask

   task automatic render_read(input string name, input logic [15:0] a, input logic [7:0] exp);
      exp_q.push_back(exp);
      @(negedge clk); VRAM_addr = a;
      @(posedge clk); #1;
      exp8 = exp_q.pop_front();
      checks++;
      if (VRAM_data !== exp8) begin
         errors++;
         $display("FAIL %s: VRAM_data=%h expected %h @%h", name, VRAM_data, exp8, a);
      end
   endtask

   task automatic check_v(input string name, input logic [13:0] exp);
      checks++;
      if (vaddr !== exp) begin
         errors++;
         $display("FAIL %s: vaddr=%h expected %h", name, vaddr, exp);
      end
   endtask

   task automatic test_reset;
      checks += 3;
      if (vaddr !== 14'h0000) begin errors++; $display("FAIL reset_v: %h expected 0000", vaddr); end
      if (cpu_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: %h expected 00", cpu_dout); end
      if (VRAM_data !== 8'h00) begin errors++; $display("FAIL reset_vdata: %h expected 00", VRAM_data); end
   endtask

   task automatic test_write_render;
      inc32 = 1'b0;
      pulse_addr(8'h21);
      pulse_addr(8'h08);
      pulse_write(8'h5A);
      pulse_write(8'h6B);
      check_v("v_after_writes", 14'h210A);
      render_read("render_2108", 16'h2108, 8'h5A);
      render_read("render_2109", 16'h2109, 8'h6B);
`ifdef VRAM_VERTICAL_MIRROR_EN
      render_read("mirror_2908", 16'h2908, 8'h5A);
`else
      render_read("mirror_2508", 16'h2508, 8'h5A);
`endif
      render_read("alias_3108", 16'h3108, 8'h5A);
      render_read("ignore_hi_bits", 16'hE109, 8'h6B);
   endtask

   task automatic test_back_to_back;
      logic [15:0] addrs [4];
      logic [7:0]  vals  [4];
      addrs = '{16'h2108, 16'h2109, 16'h2108, 16'h2109};
      vals  = '{8'h5A, 8'h6B, 8'h5A, 8'h6B};
      for (int i = 0; i < 4; i++) begin
         render_read("b2b_render", addrs[i], vals[i]);
      end
   endtask

   task automatic test_buffered_read;
      set_v(14'h0010);
      pulse_write(8'h11);
      pulse_write(8'h22);
      set_v(14'h0010);
      cpu_read("buf_stale", 8'h00);
      cpu_read("buf_first", 8'h11);
      cpu_read("buf_second", 8'h22);
      check_v("buf_v", 14'h0013);
   endtask

   task automatic test_palette;
      set_v(14'h2F00);
      pulse_write(8'h9C);
      set_v(14'h3F10);
      pulse_write(8'h3F);
      set_v(14'h3F00);
      cpu_read("pal_alias_10", 8'h3F);
      set_v(14'h0010);
      cpu_read("pal_fill_nt2f00", 8'h9C);
      set_v(14'h3F05);
      pulse_write(8'h2A);
      set_v(14'h3F25);
      cpu_read("pal_mirror_3f25", 8'h2A);
      set_v(14'h3F01);
      pulse_write(8'hFF);
      set_v(14'h3F01);
      cpu_read("pal_6bit", 8'h3F);
      render_read("pal_render_3f10", 16'h3F10, 8'h3F);
   endtask

   task automatic test_increment;
      inc32 = 1'b1;
      set_v(14'h3FF0);
      pulse_write(8'h01);
      check_v("inc32_wrap", 14'h0010);
      inc32 = 1'b0;
      set_v(14'h3FFF);
      pulse_write(8'h02);
      check_v("inc1_wrap", 14'h0000);
   endtask

   task automatic test_lockout;
      set_v(14'h2000);
      pulse_write(8'h44);
      rendering = 1'b1;
      set_v(14'h2000);
      pulse_write(8'h77);
      check_v("lock_v", 14'h2000);
      render_read("lock_mem", 16'h2000, 8'h44);
      set_v(14'h2345);
      check_v("lock_addr_wr", 14'h2345);
      rendering = 1'b0;
   endtask

   task automatic test_toggle;
      pulse_addr(8'h23);
      @(negedge clk); status_rd = 1'b1;
      @(posedge clk); #1 status_rd = 1'b0;
      pulse_addr(8'h24);
      pulse_addr(8'h00);
      check_v("toggle_clear", 14'h2400);
   endtask

   task automatic test_priority;
      set_v(14'h0020);
      @(negedge clk); addr_wr = 1'b1; data_wr = 1'b1; cpu_din = 8'h05;
      @(posedge clk); #1 addr_wr = 1'b0; data_wr = 1'b0;
      @(posedge clk);
      pulse_addr(8'h66);
      check_v("prio_addr_over_data", 14'h0566);
   endtask

   task automatic test_reset_fill;
      set_v(14'h0010);
      @(negedge clk); data_rd = 1'b1;
      @(posedge clk); #1 data_rd = 1'b0; reset = 1'b1;
      #1;
      test_reset();
      @(negedge clk); reset = 1'b0;
      @(posedge clk);
      cpu_read("fill_abandoned", 8'h00);
   endtask

   initial begin
      reset = 1'b1; VRAM_addr = '0; rendering = 1'b0; addr_wr = 1'b0; data_wr = 1'b0;
      data_rd = 1'b0; status_rd = 1'b0; inc32 = 1'b0; cpu_din = '0;
      repeat (2) @(posedge clk);
      #1 test_reset();
      @(negedge clk); reset = 1'b0;
      test_write_render();
      test_back_to_back();
      test_buffered_read();
      test_palette();
      test_increment();
      test_lockout();
      test_toggle();
      test_priority();
      test_reset_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
